// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, sequencer states, pc_sel and fault codes
package core_pkg;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT,
    S_TRAP
  } state_e;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_REL   = 2'b01;
  localparam logic [1:0] PC_SEL_JALR  = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_IMEM_TO = 2'b10;
  localparam logic [1:0] FAULT_DMEM_TO = 2'b11;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_legal_opcode = 1'b1;
      default:                           is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - memory wait counter with clear, enable and expired flag
module wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

  logic [W-1:0] r_count;
  logic         w_expired;

  // Expires on the LIMIT-th consecutive enabled cycle; LIMIT of 0 never expires.
  assign w_expired = (LIMIT != 0) && en_i && (r_count == LAST);
  assign expired_o = w_expired;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i && !w_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle fetch/decode/execute/mem/writeback sequencer
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [6:0]       opcode_i,
  input  logic             reg_write_i,
  input  logic             mem_write_i,
  input  logic             mem_to_reg_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic             jalr_i,
  input  logic             branch_taken_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  input  logic             halt_req_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic             retire_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [1:0]       fault_code_o,
  output logic [CNT_W-1:0] instret_o
);

  state_e           r_state;
  state_e           w_next;
  logic [1:0]       r_fault_code;
  logic [1:0]       w_next_fault;
  logic [CNT_W-1:0] r_instret;
  logic             w_wait_state;
  logic             w_ready;
  logic             w_expired;

  // FETCH and MEM never follow each other, so one timer serves both waits.
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ready      = (r_state == S_FETCH) ? imem_ready_i : dmem_ready_i;

  wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (!w_wait_state),
    .en_i     (w_wait_state && !w_ready),
    .expired_o(w_expired)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_RESET;
      r_fault_code <= FAULT_NONE;
    end else begin
      r_state      <= w_next;
      r_fault_code <= w_next_fault;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_instret <= '0;
    end else if (r_state == S_WRITEBACK) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_next_fault = r_fault_code;
    imem_req_o   = 1'b0;
    ir_we_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    rf_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_sel_o     = PC_SEL_PLUS4;
    retire_o     = 1'b0;
    halted_o     = 1'b0;
    fault_o      = 1'b0;

    case (r_state)
      S_RESET: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_we_o = 1'b1;
          w_next  = S_DECODE;
        end else if (w_expired) begin
          w_next       = S_TRAP;
          w_next_fault = FAULT_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (is_legal_opcode(opcode_i)) begin
          w_next = S_EXECUTE;
        end else begin
          w_next       = S_TRAP;
          w_next_fault = FAULT_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        w_next = (mem_write_i || mem_to_reg_i) ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = mem_write_i;
        if (dmem_ready_i) begin
          w_next = S_WRITEBACK;
        end else if (w_expired) begin
          w_next       = S_TRAP;
          w_next_fault = FAULT_DMEM_TO;
        end
      end
      S_WRITEBACK: begin
        pc_we_o  = 1'b1;
        retire_o = 1'b1;
        rf_we_o  = reg_write_i;
        if (jalr_i) begin
          pc_sel_o = PC_SEL_JALR;
        end else if (jump_i || (branch_i && branch_taken_i)) begin
          pc_sel_o = PC_SEL_REL;
        end
        w_next = halt_req_i ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted_o = 1'b1;
        if (!halt_req_i) begin
          w_next = S_FETCH;
        end
      end
      S_TRAP: begin
        fault_o = 1'b1;
      end
    endcase
  end

  assign fault_code_o = r_fault_code;
  assign instret_o    = r_instret;

endmodule
